// File: rtl/mult_div_unit_if.sv
// Bundle of the D/E-side operand/op signals and the multiply/divide unit's
// results. master = E stage / pipeline side, slave = mult_div_unit.
interface mult_div_unit_if;
  logic [3:0]  E_MDop;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        md_start;
  logic        md_busy;
  logic        md_block;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] E_MDout;

  modport master (
    output E_MDop, E_A, E_B,
    input  md_start, md_busy, md_block, HI, LO, E_MDout
  );

  modport slave (
    input  E_MDop, E_A, E_B,
    output md_start, md_busy, md_block, HI, LO, E_MDout
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding architectural HI/LO.
// The result is computed at start time into hi_tmp/lo_tmp and committed
// after a busy countdown that emulates hardware latency.
// Optional feature macro: MD_MADD_EN enables MADD/MADDU (ops 9/10).
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave md
);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10
  } md_op_e;

  typedef enum logic {IDLE, BUSY} state_e;

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;

  logic          is_mul, is_div, is_start, start;
  logic [63:0]   prod_s, prod_u, result;
  logic          b_zero;
  logic [31:0]   a_mag, b_mag, div_s, q_mag, r_mag, quot_s, rem_s;
  logic [31:0]   div_u, quot_u, rem_u;

  // Op decode: which codes start a timed operation and which latency applies.
  always_comb begin
    is_div = (md.E_MDop == OP_DIV) || (md.E_MDop == OP_DIVU);
`ifdef MD_MADD_EN
    is_mul = (md.E_MDop == OP_MULT) || (md.E_MDop == OP_MULTU) ||
             (md.E_MDop == OP_MADD) || (md.E_MDop == OP_MADDU);
`else
    is_mul = (md.E_MDop == OP_MULT) || (md.E_MDop == OP_MULTU);
`endif
    is_start = is_mul || is_div;
  end

  // Arithmetic datapath. Signed divide works on magnitudes so the
  // 0x80000000 / -1 case falls out as LO=0x80000000, HI=0 without traps.
  always_comb begin
    prod_s = {{32{md.E_A[31]}}, md.E_A} * {{32{md.E_B[31]}}, md.E_B};
    prod_u = {32'b0, md.E_A} * {32'b0, md.E_B};
    b_zero = (md.E_B == '0);
    a_mag  = md.E_A[31] ? (-md.E_A) : md.E_A;
    b_mag  = md.E_B[31] ? (-md.E_B) : md.E_B;
    div_s  = b_zero ? 32'd1 : b_mag;
    q_mag  = a_mag / div_s;
    r_mag  = a_mag % div_s;
    quot_s = (md.E_A[31] ^ md.E_B[31]) ? (-q_mag) : q_mag;
    rem_s  = md.E_A[31] ? (-r_mag) : r_mag;
    div_u  = b_zero ? 32'd1 : md.E_B;
    quot_u = md.E_A / div_u;
    rem_u  = md.E_A % div_u;
    result = {hi_q, lo_q};
    case (md.E_MDop)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      // Divide by zero commits the current HI/LO, i.e. leaves them unchanged.
      OP_DIV:   result = b_zero ? {hi_q, lo_q} : {rem_s, quot_s};
      OP_DIVU:  result = b_zero ? {hi_q, lo_q} : {rem_u, quot_u};
`ifdef MD_MADD_EN
      OP_MADD:  result = {hi_q, lo_q} + prod_s;
      OP_MADDU: result = {hi_q, lo_q} + prod_u;
`endif
      default:  result = {hi_q, lo_q};
    endcase
  end

  // Next-state logic: IDLE accepts starts and MTHI/MTLO; BUSY counts down and commits.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    start    = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_start) begin
          start    = 1'b1;
          state_d  = BUSY;
          cnt_d    = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          hi_tmp_d = result[63:32];
          lo_tmp_d = result[31:0];
        end else if (md.E_MDop == OP_MTHI) begin
          hi_d = md.E_A;
        end else if (md.E_MDop == OP_MTLO) begin
          lo_d = md.E_A;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          hi_d    = hi_tmp_q;
          lo_d    = lo_tmp_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; reset mid-operation drops the pending result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      hi_tmp_q <= '0;
      lo_tmp_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
    end
  end

  assign md.md_start = start;
  assign md.md_busy  = (state_q == BUSY);
  assign md.md_block = start | (state_q == BUSY);
  assign md.HI       = hi_q;
  assign md.LO       = lo_q;
  assign md.E_MDout  = (md.E_MDop == OP_MFHI) ? hi_q :
                       (md.E_MDop == OP_MFLO) ? lo_q : '0;

endmodule
